// File: rtl/rle_stream_packer.sv
// rle_stream_packer
//   Packs the 16-bit RLE word stream into 128-bit lines (eight words per line)
//   and writes each line into a circular buffer in main memory. A partial line
//   is written with a byte mask when a flush is requested or when the input
//   has gone idle for IDLE_FLUSH cycles while words are buffered.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   input_S1/avail_S1  upstream word and its valid; read_S1 pops it
//   flush              single-cycle request to write out any partial line
//   ram_addr/ram_data_to_main/ram_mask/ram_we
//                      line write request, held until accepted (ram_full=0)
//   ram_full           main RAM stalls the write this cycle
//   wrapped            one-cycle pulse after the ring pointer returns to base
//   lines_written      accepted line writes since reset (wraps mod 2^32)
//   running            block busy

// One 16-bit slot of the line being assembled, with its byte enables.
module rle_pack_lane #(
    parameter int VEC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [VEC_W-1:0]   word,
    output logic [VEC_W-1:0]   data,
    output logic [VEC_W/8-1:0] mask
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            mask <= '0;
        end else if (clear) begin
            data <= '0;
            mask <= '0;
        end else if (load) begin
            data <= word;
            mask <= '1;
        end
    end
endmodule

module rle_stream_packer #(
    parameter logic [26:0] BASE_ADDR  = 27'h0,
    parameter int          LINE_COUNT = 1024,
    parameter int          IDLE_FLUSH = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  input_S1,
    input  logic         avail_S1,
    output logic         read_S1,
    input  logic         flush,
    output logic [26:0]  ram_addr,
    output logic [127:0] ram_data_to_main,
    output logic [15:0]  ram_mask,
    output logic         ram_we,
    input  logic         ram_full,
    output logic         wrapped,
    output logic [31:0]  lines_written,
    output logic         running
);
    localparam int NUM_LANES = 8;
    localparam int VEC_W     = 16;
    localparam int IDX_W     = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1;
    localparam int IDLE_W    = (IDLE_FLUSH > 0) ? $clog2(IDLE_FLUSH + 1) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LINE_COUNT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(IDLE_FLUSH);
    localparam bit                IDLE_EN  = (IDLE_FLUSH != 0);

    typedef enum logic {FILL, WRITE} state_t;
    state_t state, state_nxt;

    logic [NUM_LANES-1:0][VEC_W-1:0]   lane_data;
    logic [NUM_LANES-1:0][VEC_W/8-1:0] lane_mask;
    logic [3:0]        count;
    logic [3:0]        count_inc;
    logic [IDX_W-1:0]  line_idx;
    logic [IDLE_W-1:0] idle_cnt;
    logic              flush_pending;
    logic              rd, accept, flush_req, flush_clr, idle_hit;

    // Lane k captures the word read while count == k.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        rle_pack_lane #(.VEC_W(VEC_W)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .load  (rd && (count == 4'(k))),
            .clear (accept),
            .word  (input_S1),
            .data  (lane_data[k]),
            .mask  (lane_mask[k])
        );
    end

    assign idle_hit  = IDLE_EN && (idle_cnt == IDLE_LIM);
    // A flush seen this cycle acts immediately, so a word read in the same
    // cycle lands in the flushed line.
    assign flush_req = flush | flush_pending | idle_hit;

    always_comb begin
        state_nxt = state;
        rd        = 1'b0;
        accept    = 1'b0;
        flush_clr = 1'b0;
        count_inc = count;
        case (state)
            FILL: begin
                rd        = avail_S1;
                count_inc = count + 4'(avail_S1);
                // An empty line satisfies the flush without a write.
                flush_clr = flush_req;
                if (count_inc == 4'd8 || (flush_req && count_inc != 4'd0))
                    state_nxt = WRITE;
            end
            WRITE: begin
                if (!ram_full) begin
                    accept    = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count         <= '0;
            line_idx      <= '0;
            idle_cnt      <= '0;
            flush_pending <= 1'b0;
            wrapped       <= 1'b0;
            lines_written <= '0;
        end else begin
            wrapped <= 1'b0;
            if (accept) begin
                count         <= '0;
                lines_written <= lines_written + 32'd1;
                if (line_idx == LAST_IDX) begin
                    line_idx <= '0;
                    wrapped  <= 1'b1;
                end else begin
                    line_idx <= line_idx + IDX_W'(1);
                end
            end else if (rd) begin
                count <= count_inc;
            end

            // A flush arriving during WRITE waits for FILL to be re-entered.
            if (flush_clr)  flush_pending <= 1'b0;
            else if (flush) flush_pending <= 1'b1;

            if (rd || state == WRITE)
                idle_cnt <= '0;
            else if (count != 4'd0 && idle_cnt != IDLE_LIM)
                idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    // Gated with rst so the combinational outputs read as idle during reset.
    assign read_S1          = rd & ~rst;
    assign ram_we           = (state == WRITE);
    assign ram_addr         = BASE_ADDR + 27'({line_idx, 4'b0000});
    assign ram_data_to_main = lane_data;
    assign ram_mask         = lane_mask;
    assign running          = ~rst & (ram_we | (count != 4'd0) | avail_S1 | flush_pending);
endmodule

// File: tb/tb_rle_stream_packer.sv
module tb_rle_stream_packer;
  localparam logic [26:0] BASE = 27'h0000340;
  localparam int LC   = 2;
  localparam int IDLE = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  input_S1 = 16'hBEEF;
  logic         avail_S1 = 1'b1;
  logic         read_S1;
  logic         flush = 1'b0;
  logic [26:0]  ram_addr;
  logic [127:0] ram_data_to_main;
  logic [15:0]  ram_mask;
  logic         ram_we;
  logic         ram_full = 1'b0;
  logic         wrapped;
  logic [31:0]  lines_written;
  logic         running;

  rle_stream_packer #(.BASE_ADDR(BASE), .LINE_COUNT(LC), .IDLE_FLUSH(IDLE)) dut (
    .clk(clk), .rst(rst), .input_S1(input_S1), .avail_S1(avail_S1), .read_S1(read_S1),
    .flush(flush), .ram_addr(ram_addr), .ram_data_to_main(ram_data_to_main),
    .ram_mask(ram_mask), .ram_we(ram_we), .ram_full(ram_full), .wrapped(wrapped),
    .lines_written(lines_written), .running(running)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: words group into lines of eight; a flush or an idle
  // timeout closes a partial group; accepted lines walk the ring.
  typedef struct {
    logic [127:0] data;
    logic [15:0]  mask;
    int           cyc;
    bit           lat;
  } line_t;

  line_t       exp_q[$];
  logic [15:0] grp[$];
  logic [15:0] src[$];
  int  acc = 0, cyc = 0, idle_run = 0, wraps_seen = 0, bp_left = 0, stall_seen = 0;
  bit  wrap_exp = 0, prev_we = 0, we_rose = 0;
  logic [127:0] last_data;
  logic [15:0]  last_mask;
  logic [26:0]  last_addr;

  function automatic line_t mk_line(input bit lat);
    line_t l;
    l.data = '0;
    l.mask = '0;
    for (int i = 0; i < grp.size(); i++) begin
      l.data[16*i +: 16] = grp[i];
      l.mask[2*i +: 2]   = 2'b11;
    end
    l.cyc = cyc;
    l.lat = lat;
    return l;
  endfunction

  task automatic monitor();
    cyc++;
    we_rose = 0;
    chk("lines_written", lines_written, acc);
    chk("wrapped", wrapped, wrap_exp);
    if (wrapped) wraps_seen++;
    wrap_exp = 0;
    if (ram_we) begin
      chk("read_in_write", read_S1, 0);
      if (ram_full) stall_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_we", ram_we, 0);
      end else begin
        if (!prev_we) begin
          we_rose = 1;
          if (exp_q[0].lat) chk("we_latency", cyc, exp_q[0].cyc + 1);
        end
        chk("addr", ram_addr, BASE + 27'(16 * (acc % LC)));
        chk("data", ram_data_to_main, exp_q[0].data);
        chk("mask", ram_mask, exp_q[0].mask);
        if (!ram_full) begin
          last_data = ram_data_to_main;
          last_mask = ram_mask;
          last_addr = ram_addr;
          void'(exp_q.pop_front());
          acc++;
          if (acc % LC == 0) wrap_exp = 1;
        end
      end
    end else begin
      chk("read_fill", read_S1, avail_S1);
    end
    prev_we = ram_we;
    if (read_S1) begin
      idle_run = 0;
      if (src.size() == 0) chk("read_empty", read_S1, 0);
      else grp.push_back(src.pop_front());
      if (grp.size() == 8) begin
        exp_q.push_back(mk_line(1));
        grp.delete();
      end
    end else if (grp.size() > 0 && !avail_S1) begin
      idle_run++;
      if (idle_run == IDLE) begin
        exp_q.push_back(mk_line(0));
        grp.delete();
        idle_run = 0;
      end
    end
    if (flush) begin
      if (grp.size() > 0) exp_q.push_back(mk_line(1));
      grp.delete();
      idle_run = 0;
    end
  endtask

  task automatic step(input bit want, input bit fl, input bit full);
    @(posedge clk);
    #1;
    avail_S1 = want && (src.size() > 0);
    input_S1 = (src.size() > 0) ? src[0] : 16'h0;
    flush    = fl;
    ram_full = full;
    if (ram_we && bp_left > 0) begin
      ram_full = 1'b1;
      bp_left--;
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) step(0, 0, 0);
    chk("pending_lines", exp_q.size(), 0);
  endtask

  // Offers n random words with at most maxgap consecutive idle cycles and
  // ram_full asserted with probability pfull percent.
  task automatic feed(input int n, input int maxgap, input int pfull);
    int gap = 0, budget = 0;
    bit want;
    for (int i = 0; i < n; i++) src.push_back(16'($urandom));
    while (src.size() > 0 && budget < 1000) begin
      want = (gap >= maxgap) || ($urandom_range(0, 1) == 1);
      gap  = want ? 0 : gap + 1;
      step(want, 0, $urandom_range(0, 99) < pfull);
      budget++;
    end
    chk("feed_timeout", src.size(), 0);
  endtask

  initial begin
    logic [15:0] a, b, c;
    int rd_cyc, we_cyc, acc0;

    // Reset state, with avail asserted to show read_S1 stays low.
    @(posedge clk);
    #2;
    chk("rst_read", read_S1, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_wrapped", wrapped, 0);
    chk("rst_lines", lines_written, 0);
    chk("rst_addr", ram_addr, BASE);
    chk("rst_data", ram_data_to_main, 0);
    chk("rst_mask", ram_mask, 0);
    chk("rst_running", running, 0);
    @(negedge clk);
    avail_S1 = 0;
    rst = 0;

    // Full line 1..8 back to back.
    for (int i = 1; i <= 8; i++) src.push_back(16'(i));
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    drain();
    chk("full_count", lines_written, 1);
    chk("full_addr", last_addr, BASE);
    chk("full_data", last_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    chk("full_mask", last_mask, 16'hFFFF);

    // 16 more words: lines at BASE+16 then BASE, one wrap pulse.
    feed(16, 0, 0);
    drain();
    chk("wrap_pulses", wraps_seen, 1);
    chk("wrap_count", lines_written, 3);
    chk("wrap_addr", last_addr, BASE);

    // Backpressure: five stalled cycles with avail held high.
    bp_left = 5;
    stall_seen = 0;
    feed(16, 0, 0);
    drain();
    chk("bp_stalls", stall_seen, 5);
    chk("bp_count", lines_written, 5);

    // Partial flush; third word arrives in the flush cycle.
    a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
    src.push_back(a); src.push_back(b); src.push_back(c);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    drain();
    chk("partial_mask", last_mask, 16'h003F);
    chk("partial_data", last_data, {80'h0, c, b, a});

    // Idle timeout: one word then silence.
    src.push_back(16'($urandom));
    step(1, 0, 0);
    rd_cyc = cyc;
    we_cyc = -1;
    for (int i = 0; i < 20 && we_cyc < 0; i++) begin
      step(0, 0, 0);
      if (we_rose) we_cyc = cyc;
    end
    chk("idle_seen", we_cyc >= 0, 1);
    chk("idle_not_early", (we_cyc - rd_cyc) > IDLE, 1);
    chk("idle_not_late", (we_cyc - rd_cyc) <= IDLE + 3, 1);
    drain();
    chk("idle_mask", last_mask, 16'h0003);

    // Flush with nothing buffered writes nothing.
    acc0 = acc;
    step(0, 1, 0);
    drain();
    chk("flush_empty", lines_written, acc0);

    // Random traffic with backpressure and occasional flushes.
    for (int it = 0; it < 40; it++) begin
      feed($urandom_range(1, 30), 2, 30);
      if ($urandom_range(0, 2) == 0) begin
        step(0, 1, 0);
        drain();
      end
    end
    step(0, 1, 0);
    drain();

    // Async reset while a write is stalled.
    for (int i = 0; i < 8; i++) src.push_back(16'($urandom));
    for (int i = 0; i < 8; i++) step(1, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    chk("pre_rst_we", ram_we, 1);
    #2;
    rst = 1;
    #1;
    chk("arst_we", ram_we, 0);
    chk("arst_addr", ram_addr, BASE);
    chk("arst_lines", lines_written, 0);
    chk("arst_data", ram_data_to_main, 0);
    exp_q.delete(); grp.delete(); src.delete();
    acc = 0; wrap_exp = 0; prev_we = 0; idle_run = 0;
    avail_S1 = 0; flush = 0; ram_full = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;

    // Clean line after reset.
    for (int i = 0; i < 8; i++) src.push_back(16'($urandom));
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    drain();
    chk("post_rst_count", lines_written, 1);
    chk("post_rst_addr", last_addr, BASE);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
